// File: rtl/pulse_pair_gen_pkg.sv
// Shared definitions for the pulse-pair generator and the pulse-order detector.
package pulse_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    GAP1   = 3'd2,
    SECOND = 3'd3,
    GAP2   = 3'd4
  } state_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  localparam int unsigned GAP_CYCLES_DEFAULT = 1;
  localparam int unsigned CNT_W_DEFAULT      = 4;

endpackage

// File: rtl/sat_step_counter.sv
// Signed saturating up/down counter of queued steps. A launch moves the
// count one step toward zero; requests that would leave the symmetric range
// are dropped and flagged for one cycle.
module sat_step_counter
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             launch_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  localparam int unsigned          EW   = CNT_W + 2;
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] MAXV = EW'((1 << (CNT_W - 1)) - 1);
  localparam logic signed [EW-1:0] MINV = -MAXV;

  logic signed [CNT_W-1:0] count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic signed [EW-1:0]    cur, req, lsign, base, cand;

  // Next count: apply launch first (always in range), then the request if it fits.
  always_comb begin
    cur   = {{2{count_q[CNT_W-1]}}, count_q};
    req   = '0;
    lsign = '0;
    if (inc_i && !dec_i) begin
      req = ONE;
    end else if (dec_i && !inc_i) begin
      req = -ONE;
    end
    if (launch_i) begin
      if (count_q[CNT_W-1]) begin
        lsign = -ONE;
      end else if (count_q != '0) begin
        lsign = ONE;
      end
    end
    base    = cur - lsign;
    cand    = base + req;
    count_d = cand[CNT_W-1:0];
    ovf_d   = 1'b0;
    if (req != '0 && (cand > MAXV || cand < MINV)) begin
      count_d = base[CNT_W-1:0];
      ovf_d   = 1'b1;
    end
  end

  // Count and overflow flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pulse_pair_gen.sv
// Turns single-cycle inc/dec requests into ordered pulse pairs
// (inc: pulse1 then pulse2, dec: pulse2 then pulse1), queuing requests that
// arrive while a pair is in flight.
module pulse_pair_gen
  import pulse_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic             pulse1,
  output logic             pulse2,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             ovf
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [3:0] gap_q, gap_d;
  logic       launch;
  logic       pend_nz, last_gap;
  logic       pulse1_q, pulse2_q, busy_q;

  sat_step_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .inc_i   (inc),
    .dec_i   (dec),
    .launch_i(launch),
    .count_o (pending),
    .ovf_o   (ovf)
  );

  assign pend_nz  = (pending != '0);
  assign last_gap = (gap_q == GAP_LAST);

  // Next-state logic; a launch overrides whatever IDLE/GAP2 would otherwise do.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    gap_d   = gap_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        launch = pend_nz;
      end
      FIRST: begin
        state_d = GAP1;
        gap_d   = '0;
      end
      GAP1: begin
        if (last_gap) begin
          state_d = SECOND;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      SECOND: begin
        state_d = GAP2;
        gap_d   = '0;
      end
      GAP2: begin
        if (last_gap) begin
          if (pend_nz) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d = FIRST;
      dir_d   = pending[CNT_W-1] ? DIR_DEC : DIR_INC;
    end
  end

  // State registers plus outputs decoded from the next state, so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dir_q    <= DIR_INC;
      gap_q    <= '0;
      pulse1_q <= 1'b0;
      pulse2_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      gap_q    <= gap_d;
      pulse1_q <= (state_d == FIRST && dir_d == DIR_INC) || (state_d == SECOND && dir_d == DIR_DEC);
      pulse2_q <= (state_d == FIRST && dir_d == DIR_DEC) || (state_d == SECOND && dir_d == DIR_INC);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign pulse1 = pulse1_q;
  assign pulse2 = pulse2_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_pulse_pair_gen.sv
// Bench for pulse_pair_gen: two instances (GAP=1/CNT_W=3 and GAP=3/CNT_W=4)
// share the request inputs and are each compared against a step-position model.
module tb_pulse_pair_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [1:0] dp1, dp2, dbusy, dovf;
  logic [2:0] pend_a;
  logic [3:0] pend_b;
  int         dpend[2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pulse_pair_gen #(.GAP_CYCLES(1), .CNT_W(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec),
    .pulse1(dp1[0]), .pulse2(dp2[0]), .busy(dbusy[0]), .pending(pend_a), .ovf(dovf[0])
  );

  pulse_pair_gen #(.GAP_CYCLES(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec),
    .pulse1(dp1[1]), .pulse2(dp2[1]), .busy(dbusy[1]), .pending(pend_b), .ovf(dovf[1])
  );

  always_comb begin
    dpend[0] = int'($signed(pend_a));
    dpend[1] = int'($signed(pend_b));
  end

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int max_of(input int k);
    return (k == 0) ? 3 : 7;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a step is active for 2+2G cycles counted by ph; first pulse at ph=0, second at ph=G+1.
  int m_pend[2], m_ph[2], m_dir[2];
  bit m_act[2], m_ovf[2];

  task automatic model_step(input int k, input bit i, input bit d);
    int  per, ls, req, base, cand;
    bit  launch;
    per    = 2 + 2 * gap_of(k);
    launch = (m_pend[k] != 0) && (!m_act[k] || m_ph[k] == per - 1);
    ls     = 0;
    if (launch) begin
      m_dir[k] = (m_pend[k] > 0) ? 1 : -1;
      ls       = m_dir[k];
      m_act[k] = 1'b1;
      m_ph[k]  = 0;
    end else if (m_act[k]) begin
      if (m_ph[k] == per - 1) m_act[k] = 1'b0;
      else m_ph[k]++;
    end
    req  = int'(i) - int'(d);
    base = m_pend[k] - ls;
    cand = base + req;
    if (req != 0 && (cand > max_of(k) || cand < -max_of(k))) begin
      m_pend[k] = base;
      m_ovf[k]  = 1'b1;
    end else begin
      m_pend[k] = cand;
      m_ovf[k]  = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = 0; m_ph[k] = 0; m_dir[k] = 1; m_act[k] = 1'b0; m_ovf[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k, inc, dec);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        bit e1, e2;
        e1 = m_act[k] && ((m_ph[k] == 0 && m_dir[k] > 0) || (m_ph[k] == gap_of(k) + 1 && m_dir[k] < 0));
        e2 = m_act[k] && ((m_ph[k] == 0 && m_dir[k] < 0) || (m_ph[k] == gap_of(k) + 1 && m_dir[k] > 0));
        chk($sformatf("model_pulse1[%0d]", k), int'(dp1[k]), int'(e1));
        chk($sformatf("model_pulse2[%0d]", k), int'(dp2[k]), int'(e2));
        chk($sformatf("model_busy[%0d]", k), int'(dbusy[k]), int'(m_act[k]));
        chk($sformatf("model_ovf[%0d]", k), int'(dovf[k]), int'(m_ovf[k]));
        chk($sformatf("model_pending[%0d]", k), dpend[k], m_pend[k]);
        chk($sformatf("exclusive[%0d]", k), int'(dp1[k] & dp2[k]), 0);
      end
    end
  end

  // Per-scenario accumulators, updated only by the stimulus process.
  int cnt_p1[2], cnt_p2[2], peak[2], p1_n[2], ncyc;
  int p1_at[2][2];

  task automatic clear_acc();
    ncyc = 0;
    for (int k = 0; k < 2; k++) begin
      cnt_p1[k] = 0; cnt_p2[k] = 0; peak[k] = 0; p1_n[k] = 0;
      p1_at[k][0] = 0; p1_at[k][1] = 0;
    end
  endtask

  // Present one request cycle; returns at the negedge after the sampling edge.
  task automatic cyc(input bit i, input bit d);
    inc = i;
    dec = d;
    @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cnt_p1[k] += int'(dp1[k]);
      cnt_p2[k] += int'(dp2[k]);
      if (dpend[k] > peak[k]) peak[k] = dpend[k];
      if (dp1[k]) begin
        if (p1_n[k] < 2) p1_at[k][p1_n[k]] = ncyc;
        p1_n[k]++;
      end
    end
    ncyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((dbusy != 2'b00 || dpend[0] != 0 || dpend[1] != 0) && n < budget) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    chk("drain_idle", int'(dbusy == 2'b00 && dpend[0] == 0 && dpend[1] == 0), 1);
  endtask

  task automatic single_step(input bit is_dec);
    logic [9:0] a_f, a_s, a_bs, b_f, b_s, b_bs;
    logic [1:0] fl, sl;
    a_f = 10'b0000000010; a_s = 10'b0000001000; a_bs = 10'b0000011110;
    b_f = 10'b0000000010; b_s = 10'b0000100000; b_bs = 10'b0111111110;
    clear_acc();
    for (int e = 0; e < 10; e++) begin
      cyc(e == 0 && !is_dec, e == 0 && is_dec);
      fl = is_dec ? dp2 : dp1;
      sl = is_dec ? dp1 : dp2;
      chk("single_a_first", int'(fl[0]), int'(a_f[e]));
      chk("single_a_second", int'(sl[0]), int'(a_s[e]));
      chk("single_a_busy", int'(dbusy[0]), int'(a_bs[e]));
      chk("single_b_first", int'(fl[1]), int'(b_f[e]));
      chk("single_b_second", int'(sl[1]), int'(b_s[e]));
      chk("single_b_busy", int'(dbusy[1]), int'(b_bs[e]));
      chk("single_pending", dpend[0], (e == 0) ? (is_dec ? -1 : 1) : 0);
      chk("single_model_pending", m_pend[1], (e == 0) ? (is_dec ? -1 : 1) : 0);
    end
    for (int k = 0; k < 2; k++) begin
      chk("single_p1_count", cnt_p1[k], 1);
      chk("single_p2_count", cnt_p2[k], 1);
    end
  endtask

  int sat_pend[6] = '{1, 1, 2, 3, 3, 3};
  int sat_ovf[6]  = '{0, 0, 0, 0, 1, 0};

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_ph[k] = 0; m_dir[k] = 1; m_act[k] = 1'b0; m_ovf[k] = 1'b0;
    end
    clear_acc();
    repeat (3) @(negedge clk);
    chk("in_reset_busy", int'(dbusy), 0);
    chk("in_reset_pulses", int'({dp1, dp2}), 0);
    rst_n = 1'b1;

    // Reset and idle
    for (int e = 0; e < 10; e++) begin
      cyc(1'b0, 1'b0);
      chk("idle_outputs", int'({dp1, dp2, dbusy, dovf}), 0);
      chk("idle_pending", dpend[0] | dpend[1], 0);
    end

    single_step(1'b0);
    single_step(1'b1);

    // Queue and cancel: 3 inc then 1 dec
    clear_acc();
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b1);
    drain(200);
    chk("queue_peak_a", peak[0], 2);
    chk("queue_peak_b", peak[1], 2);
    chk("queue_pairs_a", cnt_p1[0], 2);
    chk("queue_pairs_b", cnt_p1[1], 2);
    chk("queue_p2_a", cnt_p2[0], 2);
    chk("queue_spacing_a", p1_at[0][1] - p1_at[0][0], 4);
    chk("queue_spacing_b", p1_at[1][1] - p1_at[1][0], 8);

    // Simultaneous inc and dec cancel
    clear_acc();
    cyc(1'b1, 1'b1);
    chk("both_pending", dpend[0] | dpend[1], 0);
    chk("both_ovf", int'(dovf), 0);
    repeat (4) cyc(1'b0, 1'b0);
    chk("both_no_pulse", cnt_p1[0] + cnt_p2[0] + cnt_p1[1] + cnt_p2[1], 0);

    // Saturation on the 3-bit instance
    clear_acc();
    for (int e = 0; e < 6; e++) begin
      cyc(1'b1, 1'b0);
      chk("sat_pending", dpend[0], sat_pend[e]);
      chk("sat_ovf", int'(dovf[0]), sat_ovf[e]);
      chk("sat_model_pending", m_pend[0], sat_pend[e]);
    end
    drain(300);
    chk("sat_pairs_a", cnt_p1[0], 5);
    chk("sat_pairs_b", cnt_p1[1], 6);
    chk("sat_p2_a", cnt_p2[0], 5);

    // Reset during GAP1
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    chk("midreset_busy_before", int'(dbusy), 3);
    rst_n = 1'b0;
    #1;
    chk("midreset_pulses", int'({dp1, dp2}), 0);
    chk("midreset_busy", int'(dbusy), 0);
    chk("midreset_pending", dpend[0] | dpend[1], 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    clear_acc();
    repeat (10) cyc(1'b0, 1'b0);
    chk("midreset_no_p2", cnt_p2[0] + cnt_p2[1], 0);
    chk("midreset_no_p1", cnt_p1[0] + cnt_p1[1], 0);

    // Random traffic with varying density and bias
    for (int blk = 0; blk < 24; blk++) begin
      for (int c = 0; c < 80; c++) begin
        bit ri, rd;
        case (blk % 3)
          0: begin ri = ($urandom_range(0, 3) == 0); rd = ($urandom_range(0, 3) == 0); end
          1: begin ri = ($urandom_range(0, 3) != 0); rd = ($urandom_range(0, 7) == 0); end
          default: begin ri = ($urandom_range(0, 7) == 0); rd = ($urandom_range(0, 3) != 0); end
        endcase
        cyc(ri, rd);
      end
    end
    drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
